// File: rtl/hs4_clk_tx.sv
// Clocked four-phase bundled-data transmitter.
// FIFO-buffered words are issued as data_out + req_out against a synchronised ack_in.
module hs4_clk_tx #(
  parameter int WIDTH       = 2,
  parameter int DEPTH       = 4,
  parameter int SETUP_CYC   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             req_out,
  input  logic             ack_in,
  output logic             busy,
  output logic             err,
  output logic [15:0]      tx_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (SETUP_CYC > 1) ? $clog2(SETUP_CYC) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    WAIT_HI,
    WAIT_LO
  } state_t;

  logic [WIDTH-1:0]       mem_q [DEPTH];
  logic [WIDTH-1:0]       mem_d [DEPTH];
  logic [AW-1:0]          wr_q, wr_d;
  logic [AW-1:0]          rd_q, rd_d;
  logic [AW:0]            occ_q, occ_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [WIDTH-1:0]       dout_q, dout_d;
  logic                   req_q, req_d;
  logic                   err_q, err_d;
  logic [15:0]            txc_q, txc_d;

  logic ack_s;
  logic empty;
  logic full;
  logic push;
  logic pop;

  assign ack_s = sync_q[SYNC_STAGES-1];
  assign empty = (occ_q == '0);
  assign full  = (occ_q == (AW+1)'(DEPTH));
  assign push  = in_valid && !full;
  assign pop   = (state_q == IDLE) && !empty && !ack_s;

  assign in_ready = !full;
  assign data_out = dout_q;
  assign req_out  = req_q;
  assign err      = err_q;
  assign tx_count = txc_q;
  assign busy     = (state_q != IDLE) || !empty;

  always_comb begin
    mem_d  = mem_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    occ_d  = occ_q;
    sync_d = {sync_q[SYNC_STAGES-2:0], ack_in};
    if (push) begin
      mem_d[wr_q] = in_data;
      wr_d        = wr_q + 1'b1;
    end
    if (pop) begin
      rd_d = rd_q + 1'b1;
    end
    occ_d = occ_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  end

  // Handshake sequencing; every decision looks at the synchronised ack only.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    req_d   = req_q;
    err_d   = err_q;
    txc_d   = txc_q;
    unique case (state_q)
      IDLE: begin
        if (!empty && !ack_s) begin
          dout_d  = mem_q[rd_q];
          cnt_d   = CW'(SETUP_CYC - 1);
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (ack_s) begin
          err_d = 1'b1;
        end
        if (cnt_q == '0) begin
          req_d   = 1'b1;
          state_d = WAIT_HI;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WAIT_HI: begin
        if (ack_s) begin
          req_d   = 1'b0;
          state_d = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (!ack_s) begin
          txc_d   = txc_q + 16'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q   <= '{default: '0};
      wr_q    <= '0;
      rd_q    <= '0;
      occ_q   <= '0;
      sync_q  <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
      dout_q  <= '0;
      req_q   <= 1'b0;
      err_q   <= 1'b0;
      txc_q   <= '0;
    end else begin
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      occ_q   <= occ_d;
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      req_q   <= req_d;
      err_q   <= err_d;
      txc_q   <= txc_d;
    end
  end

endmodule

// File: tb/tb_hs4_clk_tx.sv
// Bench for hs4_clk_tx: transaction-level model compared every cycle,
// plus directed literal checks for latency, ordering, stale ack, reset and err.
module tb_hs4_clk_tx;

  localparam int D  = 4;
  localparam int SS = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  data_out;
  logic        req_out;
  logic        ack_in;
  logic        busy;
  logic        err;
  logic [15:0] tx_count;

  logic        ack_man = 1'b0;
  logic        ack_auto = 1'b0;
  logic        resp_en = 1'b0;

  logic [1:0]  in_data3 = '0;
  logic        in_valid3 = 1'b0;
  logic        ack3 = 1'b0;
  logic        rdy3;
  logic [1:0]  data3;
  logic        req3;
  logic        busy3;
  logic        err3;
  logic [15:0] tx3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign ack_in = resp_en ? ack_auto : ack_man;

  hs4_clk_tx u_dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .data_out(data_out), .req_out(req_out), .ack_in(ack_in),
    .busy(busy), .err(err), .tx_count(tx_count)
  );

  hs4_clk_tx #(.SETUP_CYC(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .in_data(in_data3), .in_valid(in_valid3), .in_ready(rdy3),
    .data_out(data3), .req_out(req3), .ack_in(ack3),
    .busy(busy3), .err(err3), .tx_count(tx3)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: word queue, ack history, and the in-flight transfer's progress.
  logic [1:0]    mq[$];
  logic [SS-1:0] m_h = '0;
  bit            m_hold = 0;
  bit            m_req = 0;
  bit            m_acked = 0;
  bit            m_err = 0;
  int            m_setl = 0;
  logic [1:0]    m_dout = '0;
  logic [15:0]   m_tx = '0;
  bit            m_as;
  bit            m_room;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_h = '0;
      m_hold = 0;
      m_req = 0;
      m_acked = 0;
      m_err = 0;
      m_setl = 0;
      m_dout = '0;
      m_tx = '0;
    end else begin
      m_as = m_h[SS-1];
      m_room = (mq.size() < D);
      if (!m_hold) begin
        if (mq.size() > 0 && !m_as) begin
          m_dout = mq.pop_front();
          m_hold = 1;
          m_setl = 0;
        end
      end else if (!m_req && !m_acked) begin
        if (m_as) m_err = 1;
        if (m_setl == 0) m_req = 1;
        else m_setl--;
      end else if (m_req) begin
        if (m_as) begin
          m_req = 0;
          m_acked = 1;
        end
      end else if (!m_as) begin
        m_hold = 0;
        m_acked = 0;
        m_tx++;
      end
      if (in_valid && m_room) mq.push_back(in_data);
      m_h = {m_h[SS-2:0], ack_in};
    end
  end

  always @(negedge clk) begin
    chk("m_data_out", data_out, m_dout);
    chk("m_req_out", req_out, m_req);
    chk("m_in_ready", in_ready, mq.size() < D);
    chk("m_busy", busy, m_hold || mq.size() != 0);
    chk("m_err", err, m_err);
    chk("m_tx_count", tx_count, m_tx);
  end

  // Acknowledge responder: mirrors req_out three clocks after it changes.
  int rdly = 0;
  always @(posedge clk) begin
    #1;
    if (req_out != ack_auto) begin
      rdly++;
      if (rdly >= 3) begin
        ack_auto = req_out;
        rdly = 0;
      end
    end else begin
      rdly = 0;
    end
  end

  logic [1:0] rlog[$];
  logic       req_prev = 1'b0;
  always @(negedge clk) begin
    if (req_out && !req_prev) rlog.push_back(data_out);
    req_prev = req_out;
  end

  // Call at posedge+1; returns at posedge+1 right after acceptance.
  task automatic push(input logic [1:0] d);
    int n;
    in_data = d;
    in_valid = 1'b1;
    n = 0;
    while (n < 500) begin
      @(negedge clk);
      if (in_ready) break;
      n++;
    end
    chk("push_accept", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_tx(input logic [15:0] n, input int budget);
    int k;
    k = 0;
    while (tx_count !== n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("tx_wait", tx_count, n);
  endtask

  logic [1:0] exp3 [6];

  initial begin
    exp3 = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd2};
    // 1: reset
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    chk("rst_req", req_out, 1'b0);
    chk("rst_data", data_out, 2'd0);
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_tx", tx_count, 16'd0);

    // 2: single word latency
    @(posedge clk);
    #1 resp_en = 1'b1;
    push(2'b10);
    @(negedge clk);
    chk("t2_e0_data", data_out, 2'd0);
    chk("t2_e0_busy", busy, 1'b1);
    @(negedge clk);
    chk("t2_e1_data", data_out, 2'b10);
    chk("t2_e1_req", req_out, 1'b0);
    @(negedge clk);
    chk("t2_e2_req", req_out, 1'b1);
    wait_tx(16'd1, 100);
    chk("t2_busy", busy, 1'b0);
    chk("t2_req", req_out, 1'b0);

    // 3: fill FIFO with ack held low, then drain in order
    @(posedge clk);
    #1 resp_en = 1'b0;
    ack_man = 1'b0;
    rlog.delete();
    push(2'd0);
    push(2'd1);
    push(2'd2);
    push(2'd3);
    push(2'd1);
    @(negedge clk);
    chk("t3_full", in_ready, 1'b0);
    chk("t3_req_hold", req_out, 1'b1);
    @(posedge clk);
    #1 resp_en = 1'b1;
    push(2'd2);
    wait_tx(16'd7, 600);
    chk("t3_log_n", rlog.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < rlog.size()) chk("t3_order", rlog[i], exp3[i]);
    end

    // 4: stale ack at reset release
    @(posedge clk);
    #1 resp_en = 1'b0;
    ack_man = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    push(2'd3);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t4_no_req", req_out, 1'b0);
      chk("t4_no_pop", data_out, 2'd0);
      chk("t4_err", err, 1'b0);
    end
    @(posedge clk);
    #1 ack_man = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("t4_p2_data", data_out, 2'd0);
    @(negedge clk);
    chk("t4_p3_data", data_out, 2'd3);
    chk("t4_p3_req", req_out, 1'b0);
    @(negedge clk);
    chk("t4_p4_req", req_out, 1'b1);
    @(posedge clk);
    #1 resp_en = 1'b1;
    wait_tx(16'd1, 100);
    chk("t4_err_end", err, 1'b0);

    // 5: reset while req_out is high
    @(posedge clk);
    #1 resp_en = 1'b0;
    ack_man = 1'b0;
    push(2'd1);
    push(2'd2);
    push(2'd3);
    for (int k = 0; k < 20 && !req_out; k++) @(negedge clk);
    chk("t5_req_up", req_out, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("t5_req_drop", req_out, 1'b0);
    chk("t5_ready", in_ready, 1'b1);
    chk("t5_busy", busy, 1'b0);
    chk("t5_tx", tx_count, 16'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (6) @(posedge clk);
    #1 resp_en = 1'b1;
    rlog.delete();
    push(2'd2);
    wait_tx(16'd1, 100);
    chk("t5_log_n", rlog.size(), 1);
    if (rlog.size() > 0) chk("t5_word", rlog[0], 2'd2);

    // 6: ack during SETUP (SETUP_CYC=3) sets sticky err
    @(posedge clk);
    #1 in_data3 = 2'd1;
    in_valid3 = 1'b1;
    @(posedge clk);
    #1 in_valid3 = 1'b0;
    ack3 = 1'b1;
    @(posedge clk);
    #1 ack3 = 1'b0;
    @(negedge clk);
    chk("t6_e1_data", data3, 2'd1);
    chk("t6_e1_req", req3, 1'b0);
    chk("t6_e1_err", err3, 1'b0);
    @(negedge clk);
    chk("t6_e2_err", err3, 1'b0);
    @(negedge clk);
    chk("t6_e3_err", err3, 1'b1);
    chk("t6_e3_req", req3, 1'b0);
    @(negedge clk);
    chk("t6_e4_req", req3, 1'b1);
    @(posedge clk);
    #1 ack3 = 1'b1;
    for (int k = 0; k < 20 && req3; k++) @(negedge clk);
    chk("t6_req_fall", req3, 1'b0);
    @(posedge clk);
    #1 ack3 = 1'b0;
    for (int k = 0; k < 20 && tx3 != 16'd1; k++) @(negedge clk);
    chk("t6_tx", tx3, 16'd1);
    chk("t6_err_sticky", err3, 1'b1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6_err_clr", err3, 1'b0);
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
